// File: rtl/ps2_move_sequencer.sv
// rtl/ps2_move_sequencer.sv - PS/2 Set-2 scancode decoder feeding a move-command FIFO
//
// Purpose: decodes the byte stream from PS2_Controller (E0 extended and F0 break
// prefixes), tracks held direction keys, and queues one move per fresh press for
// the maze engine. It also keeps a saturating count of moves accepted into the FIFO.
//
// Ports:
//   CLOCK_50       system clock, all state on rising edge
//   resetn         asynchronous active-low reset
//   ps2_data       received byte from PS2_Controller
//   ps2_data_en    one-cycle strobe qualifying ps2_data
//   game_enable    presses queue moves only while high
//   move_ready     engine accepts the head move this cycle
//   move_valid     FIFO non-empty
//   move_dir       head move: 00 up, 01 down, 10 left, 11 right
//   key_held       per-direction held flags, indexed by move_dir code
//   move_count     moves accepted into the FIFO, saturating at FF
//   last_scancode  last byte received
//   protocol_error one-cycle pulse on prefix timeout or illegal prefix
//   overflow       sticky flag: a move was dropped on a full FIFO

module ps2_move_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  input  logic       game_enable,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] key_held,
  output logic [7:0] move_count,
  output logic [7:0] last_scancode,
  output logic       protocol_error,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t         state, state_next;
  logic [TW-1:0]  timer, timer_next;
  logic           err_next;
  logic           make_act, brk_act;
  logic [1:0]     act_dir;

  logic           wasd_hit, arrow_hit;
  logic [1:0]     wasd_dir, arrow_dir;

  logic [1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, pop, push_req, push_ok;

  // Direction decode for both key families
  always_comb begin
    wasd_hit  = 1'b1;
    wasd_dir  = 2'b00;
    case (ps2_data)
      8'h1D:   wasd_dir = 2'b00;
      8'h1B:   wasd_dir = 2'b01;
      8'h1C:   wasd_dir = 2'b10;
      8'h23:   wasd_dir = 2'b11;
      default: wasd_hit = 1'b0;
    endcase
    arrow_hit = 1'b1;
    arrow_dir = 2'b00;
    case (ps2_data)
      8'h75:   arrow_dir = 2'b00;
      8'h72:   arrow_dir = 2'b01;
      8'h6B:   arrow_dir = 2'b10;
      8'h74:   arrow_dir = 2'b11;
      default: arrow_hit = 1'b0;
    endcase
  end

  // Decoder next-state and prefix timeout
  always_comb begin
    state_next = state;
    timer_next = timer;
    err_next   = 1'b0;
    make_act   = 1'b0;
    brk_act    = 1'b0;
    act_dir    = wasd_dir;
    if (ps2_data_en) begin
      timer_next = '0;
      case (state)
        S_IDLE: begin
          if (ps2_data == 8'hE0)      state_next = S_EXT;
          else if (ps2_data == 8'hF0) state_next = S_BRK;
          else if (wasd_hit)          make_act   = 1'b1;
        end
        S_EXT: begin
          if (ps2_data == 8'hF0) begin
            state_next = S_EXT_BRK;
          end else begin
            state_next = S_IDLE;
            make_act   = arrow_hit;
            act_dir    = arrow_dir;
          end
        end
        S_BRK: begin
          if (wasd_hit) begin
            brk_act    = 1'b1;
            state_next = S_IDLE;
          end else if (ps2_data == 8'hE0) begin
            // F0 E0 is out of order; flag it but honour the E0
            err_next   = 1'b1;
            state_next = S_EXT;
          end else begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
          brk_act    = arrow_hit;
          act_dir    = arrow_dir;
        end
      endcase
    end else if (state != S_IDLE) begin
      if (timer == TIMER_LAST) begin
        state_next = S_IDLE;
        err_next   = 1'b1;
        timer_next = '0;
      end else begin
        timer_next = timer + TW'(1);
      end
    end else begin
      timer_next = '0;
    end
  end

  assign move_valid = (count != '0);
  assign full       = (count == COUNT_FULL);
  assign pop        = move_valid && move_ready;
  assign push_req   = make_act && !key_held[act_dir] && game_enable;
  // A full FIFO still takes the push when the head leaves in the same cycle
  assign push_ok    = push_req && (!full || pop);
  assign move_dir   = move_valid ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      timer          <= '0;
      protocol_error <= 1'b0;
      last_scancode  <= 8'h00;
      key_held       <= 4'b0000;
      move_count     <= 8'h00;
      overflow       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 2'b00;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      protocol_error <= err_next;
      if (ps2_data_en) last_scancode <= ps2_data;
      if (make_act) key_held[act_dir] <= 1'b1;
      if (brk_act)  key_held[act_dir] <= 1'b0;
      if (push_req && !push_ok) overflow <= 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= act_dir;
        wr_ptr      <= wr_ptr + AW'(1);
        if (move_count != 8'hFF) move_count <= move_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_move_sequencer.sv
// tb/tb_ps2_move_sequencer.sv - scoreboard bench for ps2_move_sequencer
module tb_ps2_move_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_data_en = 1'b0;
  logic       game_enable = 1'b1;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] key_held;
  logic [7:0] move_count;
  logic [7:0] last_scancode;
  logic       protocol_error;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [1:0] exp_q[$];

  ps2_move_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .game_enable(game_enable), .move_ready(move_ready), .move_valid(move_valid),
    .move_dir(move_dir), .key_held(key_held), .move_count(move_count),
    .last_scancode(last_scancode), .protocol_error(protocol_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pops happen on the next rising edge whenever valid && ready at the falling edge
  always @(negedge clk) begin
    if (protocol_error) err_cnt++;
    if (resetn && move_valid && move_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", move_valid, 1'b0);
      else check("pop_dir", move_dir, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    ps2_data_en = 1'b0;
    move_ready = 1'b0;
    game_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ps2_data = b;
    ps2_data_en = 1'b1;
    @(posedge clk); #1;
    ps2_data_en = 1'b0;
  endtask

  task automatic press_release(input logic [7:0] code, input logic ext);
    if (ext) send_byte(8'hE0);
    send_byte(code);
    if (ext) send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    move_ready = 1'b1;
    while (move_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    move_ready = 1'b0;
    check({tag, "_empty"}, move_valid, 1'b0);
    check({tag, "_q_left"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, move_valid, 0);
    check({tag, "_dir"}, move_dir, 0);
    check({tag, "_held"}, key_held, 0);
    check({tag, "_count"}, move_count, 0);
    check({tag, "_last"}, last_scancode, 0);
    check({tag, "_perr"}, protocol_error, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int e0;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Extended up arrow, engine not ready
    send_byte(8'hE0);
    send_byte(8'h75);
    check("ext_valid", move_valid, 1);
    check("ext_dir", move_dir, 2'b00);
    check("ext_held", key_held, 4'b0001);
    check("ext_count", move_count, 1);
    check("ext_last", last_scancode, 8'h75);
    exp_q.push_back(2'b00);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("ext_release", key_held, 4'b0000);
    drain("ext");

    // Typematic repeat of A
    do_reset();
    send_byte(8'h1C);
    exp_q.push_back(2'b10);
    check("typ_held1", key_held, 4'b0100);
    send_byte(8'h1C);
    send_byte(8'h1C);
    check("typ_count1", move_count, 1);
    send_byte(8'hF0); send_byte(8'h1C);
    check("typ_held0", key_held, 4'b0000);
    send_byte(8'h1C);
    exp_q.push_back(2'b10);
    check("typ_held2", key_held, 4'b0100);
    check("typ_count2", move_count, 2);
    drain("typ");

    // Fill past depth: fifth move dropped
    do_reset();
    press_release(8'h1D, 0); exp_q.push_back(2'b00);
    press_release(8'h1B, 0); exp_q.push_back(2'b01);
    press_release(8'h1C, 0); exp_q.push_back(2'b10);
    press_release(8'h23, 0); exp_q.push_back(2'b11);
    check("fill_ovf0", overflow, 0);
    press_release(8'h75, 1);
    check("fill_ovf1", overflow, 1);
    check("fill_count", move_count, 4);
    drain("fill");
    check("fill_ovf_sticky", overflow, 1);

    // Push and pop together on a full FIFO
    do_reset();
    press_release(8'h1D, 0); exp_q.push_back(2'b00);
    press_release(8'h1B, 0); exp_q.push_back(2'b01);
    press_release(8'h1C, 0); exp_q.push_back(2'b10);
    press_release(8'h23, 0); exp_q.push_back(2'b11);
    send_byte(8'hE0);
    @(posedge clk); #1;
    ps2_data = 8'h72;
    ps2_data_en = 1'b1;
    move_ready = 1'b1;
    @(posedge clk); #1;
    ps2_data_en = 1'b0;
    move_ready = 1'b0;
    exp_q.push_back(2'b01);
    check("simul_ovf", overflow, 0);
    check("simul_count", move_count, 5);
    drain("simul");

    // Prefix timeout
    do_reset();
    e0 = err_cnt;
    send_byte(8'hE0);
    repeat (TMO + 5) @(posedge clk);
    #1;
    check("tmo_pulses", err_cnt - e0, 1);
    check("tmo_perr_low", protocol_error, 0);
    send_byte(8'h75);
    check("tmo_no_push", move_valid, 0);
    check("tmo_count", move_count, 0);

    // F0 then E0 is illegal but the E0 is kept
    do_reset();
    e0 = err_cnt;
    send_byte(8'hF0);
    send_byte(8'hE0);
    @(posedge clk); #1;
    check("f0e0_pulses", err_cnt - e0, 1);
    send_byte(8'h72);
    exp_q.push_back(2'b01);
    check("f0e0_dir", move_dir, 2'b01);
    check("f0e0_held", key_held, 4'b0010);
    drain("f0e0");

    // game_enable low: tracked, not queued
    do_reset();
    game_enable = 1'b0;
    send_byte(8'h23);
    check("dis_held", key_held, 4'b1000);
    check("dis_valid", move_valid, 0);
    game_enable = 1'b1;

    // Count saturation
    do_reset();
    move_ready = 1'b1;
    for (int i = 0; i < 258; i++) begin
      send_byte(8'h1D);
      exp_q.push_back(2'b00);
      if (i == 253) check("sat_fe", move_count, 8'hFE);
      send_byte(8'hF0);
      send_byte(8'h1D);
    end
    check("sat_ff", move_count, 8'hFF);
    check("sat_ovf", overflow, 0);
    drain("sat");

    // Asynchronous reset mid-sequence
    send_byte(8'h1C);
    exp_q.delete();
    send_byte(8'hE0);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("areset");
    @(posedge clk); #1;
    resetn = 1'b1;
    send_byte(8'h75);
    check("areset_idle", move_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_move_sequencer.md
Name: ps2_move_sequencer

Overview:
- Sits between PS2_Controller (received_data / received_data_en) and the maze game engine.
- Decodes the PS/2 Set-2 byte stream, handling the E0 extended prefix and the F0 break prefix, and tracks held direction keys.
- Queues one move command per fresh key press in a small FIFO, with a valid/ready handshake to the engine.
- Keeps the saturating move counter that drives the score display.

Parameters:
FIFO_DEPTH, 4, move-command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 2500000, max cycles allowed in a prefix state before abort (50 ms at 50 MHz)

Ports:
CLOCK_50  in  1  system clock, 50 MHz, all state on rising edge
resetn  in  1  asynchronous active-low reset (driven from KEY[0])
ps2_data  in  8  received byte from PS2_Controller
ps2_data_en  in  1  one-cycle strobe, ps2_data valid
game_enable  in  1  high: presses generate moves; low: presses tracked but not queued
move_ready  in  1  engine accepts head move this cycle
move_valid  out  1  FIFO non-empty
move_dir  out  2  head move: 00 up, 01 down, 10 left, 11 right
key_held  out  4  per-direction held flags, bit index = move_dir code
move_count  out  8  accepted moves, saturates at 8'hFF
last_scancode  out  8  last byte received
protocol_error  out  1  one-cycle pulse on prefix timeout or illegal prefix
overflow  out  1  sticky: a move was dropped because the FIFO was full

Behaviour:
- Reset (async, resetn=0): decoder state IDLE, FIFO empty, timeout counter 0. All outputs 0: move_valid, move_dir, key_held, move_count, last_scancode, protocol_error, overflow.
- Every ps2_data_en: last_scancode <= ps2_data.
- Decoder FSM, advances only on ps2_data_en:
  - IDLE: E0 -> EXT; F0 -> BRK; WASD make (1D W=up, 1B S=down, 1C A=left, 23 D=right) -> MAKE action, stay IDLE; any other byte (incl. AA, FA) ignored.
  - EXT: F0 -> EXT_BRK; arrow make (75 up, 72 down, 6B left, 74 right) -> MAKE action, IDLE; other -> IDLE, no action.
  - BRK: WASD code -> BREAK action, IDLE; E0 -> protocol_error, EXT; other -> IDLE.
  - EXT_BRK: arrow code -> BREAK action, IDLE; other -> IDLE.
- Timeout: counter runs while in EXT/BRK/EXT_BRK and resets on every ps2_data_en. On reaching TIMEOUT_CYCLES-1: return to IDLE and pulse protocol_error.
- MAKE(d):
  - if key_held[d]=1: typematic repeat, no push.
  - else: key_held[d]<=1; if game_enable, push d.
  - Push when FIFO full: entry dropped, overflow<=1 (sticky until reset), move_count unchanged.
- BREAK(d): key_held[d]<=0, regardless of game_enable.
- Push effects: move_count increments, holding at FF.
- Latency: final byte strobed at edge N; entry written at N; move_valid=1 and move_dir valid after edge N (visible in cycle N+1) when FIFO was empty.
- Pop on edge where move_valid && move_ready. move_dir shows the FIFO head combinationally from registered storage.
- Simultaneous push and pop:
  - On a full FIFO: both succeed, no overflow.
  - On an empty FIFO: only the push succeeds (nothing valid to pop).
- move_ready while empty: no effect. Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- game_enable falling: queued entries remain and can still be drained.
- Reset mid-sequence (e.g. after E0): FSM to IDLE, FIFO flushed, key_held cleared.

Test Plan:
- Bytes E0,75 with move_ready=0 -> move_valid=1 and move_dir=00 on the cycle after the 75 strobe; key_held=0001; move_count=1.
- Typematic: 1C,1C,1C, then F0,1C, then 1C -> exactly two left pushes (dir 10); key_held[2] 1->0->1; move_count=2.
- Fill: five distinct press/release pairs with move_ready=0 and FIFO_DEPTH=4 -> 4 entries in order, overflow=1, move_count=4. Then hold move_ready=1 -> four pops in order, move_valid=0.
- Byte E0 then no byte for TIMEOUT_CYCLES -> protocol_error one-cycle pulse, FSM IDLE. A following 75 is then ignored (no push).
- F0 then E0 -> protocol_error pulse; next 72 is treated as an extended make (down pushed).
- move_count preloaded near FF: push with count=FF -> stays FF. resetn low mid-stream (after E0) -> all outputs 0 immediately, without waiting for a clock edge.
